// File: rtl/mem_loader.sv
// mem_loader: host-side loader driving the CPU external memory ports and enable.
// Optional LOADER_CHECKSUM_EN appends a 32-bit sum of written words to the output stream.
module mem_loader #(
    parameter int IMEM_DEPTH = 128,
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic [31:0] imem_addr,
    output logic        imem_wen,
    output logic        imem_ren,
    output logic [31:0] imem_wdata,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dmem_addr,
    output logic        dmem_wen,
    output logic        dmem_ren,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    output logic        cpu_enable,
    output logic        busy,
    output logic        err
);
    typedef enum logic [2:0] {
        IDLE, WRITE, RD_REQ, RD_CAP, RD_OUT
`ifdef LOADER_CHECKSUM_EN
        , CKSUM
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc, n_q, hdr_n;
    logic [1:0]  hdr_op;
    logic        tgt_q, hdr_tgt;
    logic        hdr, wr, mem_op, depth_bad, hdr_go, hdr_bad, last;
    logic        rd_go, rd_tgt, i_acc, d_acc;
    logic [31:0] acc_addr;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_q;
`endif

    assign hdr_op    = s_data[31:30];
    assign hdr_tgt   = s_data[29];
    assign hdr_n     = s_data[15:0];
    assign hdr       = state_q == IDLE && s_valid && s_ready;
    assign wr        = state_q == WRITE && s_valid && s_ready;
    assign mem_op    = !hdr_op[1] && hdr_n != 16'd0;
    assign depth_bad = {16'd0, hdr_n} > (hdr_tgt ? 32'(DMEM_DEPTH) : 32'(IMEM_DEPTH));
    assign hdr_go    = hdr && mem_op && !cpu_enable && !depth_bad;
    assign hdr_bad   = hdr && mem_op && (cpu_enable || depth_bad);
    assign cnt_inc   = cnt_q + 16'd1;
    assign last      = cnt_inc == n_q;
    // A read request is issued on entry to RD_REQ so ren is a clean registered pulse
    assign rd_go     = state_d == RD_REQ;
    assign rd_tgt    = state_q == IDLE ? hdr_tgt : tgt_q;
    assign i_acc     = (wr && !tgt_q) || (rd_go && !rd_tgt);
    assign d_acc     = (wr && tgt_q) || (rd_go && rd_tgt);
    assign acc_addr  = {14'd0, wr ? cnt_q : cnt_d, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (hdr_go) state_d = hdr_op[0] ? RD_REQ : WRITE;
            end
            WRITE: if (wr) begin
                cnt_d = cnt_inc;
`ifdef LOADER_CHECKSUM_EN
                if (last) state_d = CKSUM;
`else
                if (last) state_d = IDLE;
`endif
            end
            RD_REQ: state_d = RD_CAP;
            RD_CAP: state_d = RD_OUT;
            RD_OUT: if (m_ready) begin
                cnt_d   = cnt_inc;
                state_d = last ? IDLE : RD_REQ;
            end
`ifdef LOADER_CHECKSUM_EN
            CKSUM: if (m_ready) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_ready = !rst && (state_q == IDLE || state_q == WRITE);
        busy    = state_q != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q        <= '0;
            tgt_q      <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            imem_addr  <= '0;
            imem_wen   <= 1'b0;
            imem_ren   <= 1'b0;
            imem_wdata <= '0;
            dmem_addr  <= '0;
            dmem_wen   <= 1'b0;
            dmem_ren   <= 1'b0;
            dmem_wdata <= '0;
            cpu_enable <= 1'b0;
            err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            if (hdr) begin
                n_q   <= hdr_n;
                tgt_q <= hdr_tgt;
            end
            if (hdr && hdr_op == 2'b10) cpu_enable <= 1'b1;
            if (hdr && hdr_op == 2'b11) cpu_enable <= 1'b0;
            if (hdr_bad) err <= 1'b1;
            imem_wen   <= wr && !tgt_q;
            dmem_wen   <= wr && tgt_q;
            imem_wdata <= (wr && !tgt_q) ? s_data : '0;
            dmem_wdata <= (wr && tgt_q) ? s_data : '0;
            imem_ren   <= rd_go && !rd_tgt;
            dmem_ren   <= rd_go && rd_tgt;
            if (i_acc) imem_addr <= acc_addr;
            if (d_acc) dmem_addr <= acc_addr;
`ifdef LOADER_CHECKSUM_EN
            m_valid <= state_d == RD_OUT || state_d == CKSUM;
            if (hdr_go && !hdr_op[0]) sum_q <= '0;
            else if (wr) sum_q <= sum_q + s_data;
            if (wr && last) m_data <= sum_q + s_data;
`else
            m_valid <= state_d == RD_OUT;
`endif
            if (state_q == RD_CAP) m_data <= tgt_q ? dmem_rdata : imem_rdata;
        end
    end
endmodule
